// File: rtl/decoder_scan_sequencer.sv
// Scan controller for an active-high decoder: steps the select through every
// channel, holds each for a programmable dwell, then blanks enable before moving on.
module decoder_scan_sequencer #(
    parameter int DATA_SIZE    = 4,
    parameter int DWELL_WIDTH  = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic                   stop_in,
    input  logic                   continuous_in,
    input  logic [DWELL_WIDTH-1:0] dwell_in,
    output logic [DATA_SIZE-2:0]   sel_out,
    output logic                   enable_out,
    output logic                   busy_out,
    output logic                   chan_strobe_out,
    output logic                   done_out
);

    localparam int SW = DATA_SIZE - 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [SW-1:0]          SEL_LAST   = SW'(DATA_SIZE - 1);
    localparam logic [SW-1:0]          SEL_ONE    = SW'(1);
    localparam logic [DWELL_WIDTH-1:0] DW_ONE     = DWELL_WIDTH'(1);
    localparam logic [BW-1:0]          BLANK_INIT = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [BW-1:0]          BLANK_ONE  = BW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

    state_t                 r_state, w_state;
    logic [SW-1:0]          r_sel, w_sel;
    logic [DWELL_WIDTH-1:0] r_cnt, w_cnt;
    logic [DWELL_WIDTH-1:0] r_dwell, w_dwell;
    logic [BW-1:0]          r_blank, w_blank;
    logic                   r_cont, w_cont;
    logic                   r_stop, w_stop;
    logic                   r_en, w_en;
    logic                   r_strobe, w_strobe;
    logic                   r_done, w_done;
    logic                   r_busy;
    logic                   w_adv;
    logic                   w_stop_req;
    logic [DWELL_WIDTH-1:0] w_dwell_eff;

    assign w_dwell_eff = (dwell_in == '0) ? DW_ONE : dwell_in;
    assign w_stop_req  = r_stop | stop_in;

    // r_cnt holds the active cycles still to come after the current one,
    // so a full 2^W-1 dwell fits in the DWELL_WIDTH counter.
    always_comb begin
        w_state  = r_state;
        w_sel    = r_sel;
        w_cnt    = r_cnt;
        w_dwell  = r_dwell;
        w_blank  = r_blank;
        w_cont   = r_cont;
        w_stop   = r_stop;
        w_en     = 1'b0;
        w_strobe = 1'b0;
        w_done   = 1'b0;
        w_adv    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel  = '0;
                w_stop = 1'b0;
                if (start_in && !stop_in) begin
                    w_dwell  = w_dwell_eff;
                    w_cont   = continuous_in;
                    w_state  = S_ACTIVE;
                    w_cnt    = w_dwell_eff - DW_ONE;
                    w_en     = 1'b1;
                    w_strobe = 1'b1;
                end
            end
            S_ACTIVE: begin
                w_stop = w_stop_req;
                if (r_cnt == '0) begin
                    if (BLANK_CYCLES > 0) begin
                        w_state = S_BLANK;
                        w_blank = BLANK_INIT;
                    end else begin
                        w_adv = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt - DW_ONE;
                    w_en  = 1'b1;
                end
            end
            S_BLANK: begin
                w_stop = w_stop_req;
                if (r_blank == '0) w_adv = 1'b1;
                else               w_blank = r_blank - BLANK_ONE;
            end
            default: w_state = S_IDLE;
        endcase

        // Select only moves here, as the next channel's first active cycle begins.
        if (w_adv) begin
            if (w_stop_req || (r_sel == SEL_LAST && !r_cont)) begin
                w_state = S_IDLE;
                w_sel   = '0;
                w_stop  = 1'b0;
                w_done  = 1'b1;
            end else begin
                w_sel    = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_ONE;
                w_state  = S_ACTIVE;
                w_cnt    = r_dwell - DW_ONE;
                w_en     = 1'b1;
                w_strobe = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_blank  <= '0;
            r_cont   <= 1'b0;
            r_stop   <= 1'b0;
            r_en     <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sel    <= w_sel;
            r_cnt    <= w_cnt;
            r_dwell  <= w_dwell;
            r_blank  <= w_blank;
            r_cont   <= w_cont;
            r_stop   <= w_stop;
            r_en     <= w_en;
            r_strobe <= w_strobe;
            r_done   <= w_done;
            r_busy   <= (w_state != S_IDLE);
        end
    end

    assign sel_out         = r_sel;
    assign enable_out      = r_en;
    assign busy_out        = r_busy;
    assign chan_strobe_out = r_strobe;
    assign done_out        = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: a per-cycle vector table plus
// hand-written sequences for wrap/stop, dwell corners and mid-scan reset.
module tb_decoder_scan_sequencer;
    localparam int DS = 4;
    localparam int SW = DS - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, start0 = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [SW-1:0] sel, sel0;
    logic en, busy, stb, done, en0, busy0, stb0, done0;

    decoder_scan_sequencer #(.DATA_SIZE(DS), .DWELL_WIDTH(8), .BLANK_CYCLES(1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop),
        .continuous_in(cont), .dwell_in(dwell), .sel_out(sel), .enable_out(en),
        .busy_out(busy), .chan_strobe_out(stb), .done_out(done));

    decoder_scan_sequencer #(.DATA_SIZE(DS), .DWELL_WIDTH(8), .BLANK_CYCLES(0)) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start0), .stop_in(stop),
        .continuous_in(cont), .dwell_in(dwell), .sel_out(sel0), .enable_out(en0),
        .busy_out(busy0), .chan_strobe_out(stb0), .done_out(done0));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] obs, obs0;
    assign obs  = {sel, en, busy, stb, done};
    assign obs0 = {sel0, en0, busy0, stb0, done0};

    typedef struct {
        logic       start, stop, cont;
        logic [7:0] dwell;
        logic [2:0] sel;
        logic       en, busy, stb, done;
    } vec_t;
    vec_t vq[$];

    function automatic logic [6:0] pk(logic [2:0] s, logic e, logic b, logic st, logic d);
        return {s, e, b, st, d};
    endfunction

    function automatic void add(logic st, logic sp, logic c, logic [7:0] dw,
                                logic [2:0] s, logic e, logic b, logic sb, logic d);
        vec_t v;
        v.start = st; v.stop = sp; v.cont = c; v.dwell = dw;
        v.sel = s; v.en = e; v.busy = b; v.stb = sb; v.done = d;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {sel,en,busy,strobe,done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dones, bad, bcnt, e0cnt, lim;

        // Record i: inputs driven before edge i, outputs expected after it.
        add(0,0,0,8'd3, 0,0,0,0,0);              // idle after reset
        add(1,1,0,8'd3, 0,0,0,0,0);              // start+stop: stop wins
        add(1,0,0,8'd3, 0,1,1,1,0);              // single shot, D=3
        add(0,0,0,8'd3, 0,1,1,0,0);
        add(0,0,0,8'd3, 0,1,1,0,0);
        add(0,0,0,8'd3, 0,0,1,0,0);
        add(0,0,0,8'd3, 1,1,1,1,0);
        add(0,0,0,8'd3, 1,1,1,0,0);
        add(0,0,0,8'd3, 1,1,1,0,0);
        add(0,0,0,8'd3, 1,0,1,0,0);
        add(0,0,0,8'd3, 2,1,1,1,0);
        add(0,0,0,8'd3, 2,1,1,0,0);
        add(0,0,0,8'd3, 2,1,1,0,0);
        add(0,0,0,8'd3, 2,0,1,0,0);
        add(0,0,0,8'd3, 3,1,1,1,0);
        add(0,0,0,8'd3, 3,1,1,0,0);
        add(0,0,0,8'd3, 3,1,1,0,0);
        add(0,0,0,8'd3, 3,0,1,0,0);
        add(0,0,0,8'd3, 0,0,0,0,1);              // done after 16 busy cycles
        add(1,0,0,8'd1, 0,1,1,1,0);              // restart in done cycle, D=1
        add(0,0,0,8'd1, 0,0,1,0,0);
        add(0,0,0,8'd1, 1,1,1,1,0);
        add(0,0,0,8'd1, 1,0,1,0,0);
        add(0,0,0,8'd1, 2,1,1,1,0);
        add(0,0,0,8'd1, 2,0,1,0,0);
        add(0,0,0,8'd1, 3,1,1,1,0);
        add(0,0,0,8'd1, 3,0,1,0,0);
        add(0,0,0,8'd1, 0,0,0,0,1);
        add(0,0,0,8'd1, 0,0,0,0,0);

        #2;
        chk("reset_state", obs, 7'd0);
        chk("reset_state_nb", obs0, 7'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vq[i]) begin
            start = vq[i].start; stop = vq[i].stop; cont = vq[i].cont; dwell = vq[i].dwell;
            step();
            chk($sformatf("vec%0d", i), obs, pk(vq[i].sel, vq[i].en, vq[i].busy, vq[i].stb, vq[i].done));
        end
        start = 0; stop = 0;

        // Dwell 0 treated as 1, no blanking: enable stays high across channels.
        dwell = 8'd0; start0 = 1; step(); start0 = 0;
        chk("dz_ch0", obs0, pk(0,1,1,1,0));
        step(); chk("dz_ch1", obs0, pk(1,1,1,1,0));
        step(); chk("dz_ch2", obs0, pk(2,1,1,1,0));
        step(); chk("dz_ch3", obs0, pk(3,1,1,1,0));
        step(); chk("dz_done", obs0, pk(0,0,0,0,1));

        // Full-width dwell: 255 active cycles per channel.
        dwell = 8'd255; start0 = 1; step(); start0 = 0;
        bcnt = busy0 ? 1 : 0;
        e0cnt = (en0 && sel0 == 0) ? 1 : 0;
        lim = 0;
        while (busy0 && lim < 2000) begin
            step(); lim++;
            if (busy0) bcnt++;
            if (en0 && sel0 == 0) e0cnt++;
        end
        chk_int("dw255_busy_cycles", bcnt, 4 * 255);
        chk_int("dw255_ch0_enable", e0cnt, 255);
        chk_int("dw255_done", int'(done0), 1);

        // Continuous wrap; start mid-scan with new dwell/mode is ignored.
        cont = 1; dwell = 8'd2; start = 1; step();
        chk("cont_start", obs, pk(0,1,1,1,0));
        dones = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 3 || c == 4) begin start = 1; dwell = 8'd9; cont = 0; end
            else start = 0;
            step();
            if (done) dones++;
            if (c == 5) chk("dwell_kept", obs, pk(1,0,1,0,0));
        end
        chk_int("no_done_before_wrap", dones, 0);
        step(); chk("wrap_to_ch0", obs, pk(0,1,1,1,0));
        step(); step();
        step(); chk("cont_ch1", obs, pk(1,1,1,1,0));
        stop = 1; step(); stop = 0;
        chk("stop_ch1_active", obs, pk(1,1,1,0,0));
        step(); chk("stop_ch1_blank", obs, pk(1,0,1,0,0));
        step(); chk("stop_done", obs, pk(0,0,0,0,1));
        bad = 0;
        repeat (6) begin step(); if (en || busy || done) bad++; end
        chk_int("ch2_never_enabled", bad, 0);

        // Reset mid-scan in channel 2.
        cont = 0; dwell = 8'd3; start = 1; step(); start = 0;
        repeat (8) step();
        chk("ch2_reached", obs, pk(2,1,1,1,0));
        step();
        #3 rst_n = 1'b0;
        #1 chk("async_reset", obs, 7'd0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        repeat (3) begin step(); if (obs != 7'd0) bad++; end
        chk_int("post_reset_idle", bad, 0);
        dwell = 8'd1; start = 1; step(); start = 0;
        chk("restart_ch0", obs, pk(0,1,1,1,0));
        lim = 0;
        while (!done && lim < 50) begin step(); lim++; end
        chk_int("restart_completes", int'(done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
